// File: rtl/device_mux_n.sv
// ============================================================================
//  Module      : device_mux_n
//  Description : 68000-style single-master to NUM_SLAVES-slave bus
//                multiplexer with base/mask address decode, registered
//                transfer sequencing, read-data capture, bus-error response
//                for unmapped addresses and a watchdog for silent slaves.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module device_mux_n #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    // Slave 0 occupies the rightmost (least significant) field: RAM at 0,
    // then UART and peripheral windows at 0x100000/0x100100/0x100200.
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h00100200, 32'h00100100, 32'h00100000, 32'h00000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFF00000},
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            master_write,
    output logic [DATA_W-1:0]            master_read,
    input  logic [ADDR_W-1:0]            master_addr,
    input  logic                         master_uds,
    input  logic                         master_lds,
    output logic                         master_ack,
    output logic                         master_berr,
    input  logic [NUM_SLAVES*DATA_W-1:0] slave_read,
    output logic [DATA_W-1:0]            slave_write,
    output logic [ADDR_W-1:0]            slave_addr,
    output logic [NUM_SLAVES-1:0]        slave_uds,
    output logic [NUM_SLAVES-1:0]        slave_lds,
    input  logic [NUM_SLAVES-1:0]        slave_ack,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Timer value on the last ACTIVE cycle before the watchdog fires.
    localparam logic [15:0] TIMEOUT_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [15:0]         timer_q, timer_d;
    logic [DATA_W-1:0]   read_q, read_d;
    logic                ack_q, ack_d;
    logic                berr_q, berr_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                hit_any;
    logic [SEL_W-1:0]    hit_idx;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_data;
    logic                master_req;

    assign master_req  = master_uds | master_lds;
    assign slave_write = master_write;
    assign slave_addr  = master_addr;
    assign master_read = read_q;
    assign master_ack  = ack_q;
    assign master_berr = berr_q;
    assign err_addr    = err_addr_q;

    // Address decode: scan downward so the lowest matching index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((master_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Pick the ack and read lane of the slave owning the current transfer.
    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ack  = slave_ack[i];
                sel_data = slave_read[i*DATA_W +: DATA_W];
            end
        end
    end

    // Forward master byte strobes only to the selected slave, only in ACTIVE.
    always_comb begin
        slave_uds = '0;
        slave_lds = '0;
        if (state_q == ST_ACTIVE) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    slave_uds[i] = master_uds;
                    slave_lds[i] = master_lds;
                end
            end
        end
    end

    // Transfer sequencer: next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        read_d     = read_q;
        ack_d      = ack_q;
        berr_d     = berr_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (master_req) begin
                    if (hit_any) begin
                        sel_d   = hit_idx;
                        timer_d = '0;
                        state_d = ST_ACTIVE;
                    end else begin
                        berr_d     = 1'b1;
                        err_addr_d = master_addr;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_ACTIVE: begin
                // A master that drops both strobes has abandoned the cycle;
                // that takes precedence over anything the slave does.
                if (!master_req) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    read_d  = sel_data;
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 0) && (timer_q == TIMEOUT_LAST)) begin
                    berr_d     = 1'b1;
                    err_addr_d = master_addr;
                    state_d    = ST_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_DONE: begin
                // Hold the response until the master releases its strobes.
                if (!master_req) begin
                    ack_d   = 1'b0;
                    berr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            timer_q    <= '0;
            read_q     <= '0;
            ack_q      <= 1'b0;
            berr_q     <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            read_q     <= read_d;
            ack_q      <= ack_d;
            berr_q     <= berr_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_device_mux_n.sv
// ============================================================================
//  Module      : tb_device_mux_n
//  Description : Self-checking bench for device_mux_n: directed scenarios
//                followed by randomized transfers against an address-map
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_device_mux_n;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 8;

    // Slave 3 is a wide window overlapping slaves 1 and 2.
    localparam logic [NS*AW-1:0] BASE =
        {32'h00100000, 32'h00100100, 32'h00100000, 32'h00000000};
    localparam logic [NS*AW-1:0] MASK =
        {32'hFFF00000, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFF00000};

    logic               clk;
    logic               reset;
    logic [DW-1:0]      master_write;
    logic [DW-1:0]      master_read;
    logic [AW-1:0]      master_addr;
    logic               master_uds;
    logic               master_lds;
    logic               master_ack;
    logic               master_berr;
    logic [NS*DW-1:0]   slave_read;
    logic [DW-1:0]      slave_write;
    logic [AW-1:0]      slave_addr;
    logic [NS-1:0]      slave_uds;
    logic [NS-1:0]      slave_lds;
    logic [NS-1:0]      slave_ack;
    logic [AW-1:0]      err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference view of what the master should currently see.
    logic [DW-1:0] m_read;
    logic [AW-1:0] m_err;

    device_mux_n #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .master_write (master_write),
        .master_read  (master_read),
        .master_addr  (master_addr),
        .master_uds   (master_uds),
        .master_lds   (master_lds),
        .master_ack   (master_ack),
        .master_berr  (master_berr),
        .slave_read   (slave_read),
        .slave_write  (slave_write),
        .slave_addr   (slave_addr),
        .slave_uds    (slave_uds),
        .slave_lds    (slave_lds),
        .slave_ack    (slave_ack),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address map as address ranges; first listed range wins.
    function automatic int ref_decode(input logic [31:0] a);
        if (a[31:20] == 12'h000)    return 0;
        if (a[31:8]  == 24'h001000) return 1;
        if (a[31:8]  == 24'h001001) return 2;
        if (a[31:20] == 12'h001)    return 3;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_uds"}, 64'(slave_uds), 64'd0);
        chk({tag, "_lds"}, 64'(slave_lds), 64'd0);
        chk({tag, "_ack"}, 64'(master_ack), 64'd0);
        chk({tag, "_berr"}, 64'(master_berr), 64'd0);
    endtask

    // One complete master transfer. ack_at is the cycle (1 = first ACTIVE
    // cycle) in which the addressed slave raises ack; values outside
    // 1..TO mean the slave stays silent.
    task automatic xfer(input logic [31:0] a, input logic u, input logic l,
                        input logic [15:0] wd, input int ack_at,
                        input logic [15:0] rd, input int hold);
        int          sel;
        int          done_c;
        bit          is_ack;
        logic [3:0]  eu, el, noise;
        sel = ref_decode(a);
        if (sel < 0) begin
            done_c = 1; is_ack = 1'b0;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            done_c = ack_at + 1; is_ack = 1'b1;
        end else begin
            done_c = TO + 1; is_ack = 1'b0;
        end
        eu = '0; el = '0;
        if (sel >= 0) begin
            eu[sel] = u;
            el[sel] = l;
        end

        @(posedge clk); #1;
        master_addr = a; master_uds = u; master_lds = l; master_write = wd;
        slave_ack = '0;
        @(negedge clk);
        chk("idle_uds", 64'(slave_uds), 64'd0);
        chk("idle_lds", 64'(slave_lds), 64'd0);
        chk("pass_wdata", 64'(slave_write), 64'(wd));
        chk("pass_addr", 64'(slave_addr), 64'(a));

        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk); #1;
            noise = 4'($urandom);
            if (sel >= 0) noise[sel] = (c == ack_at);
            slave_ack  = noise;
            slave_read = {$urandom, $urandom};
            if (sel >= 0 && c == ack_at) slave_read[sel*DW +: DW] = rd;
            @(negedge clk);
            if (c < done_c) begin
                chk("act_uds", 64'(slave_uds), 64'(eu));
                chk("act_lds", 64'(slave_lds), 64'(el));
                chk("act_ack", 64'(master_ack), 64'd0);
                chk("act_berr", 64'(master_berr), 64'd0);
            end else begin
                if (is_ack) m_read = rd;
                else        m_err  = a;
                chk("done_uds", 64'(slave_uds), 64'd0);
                chk("done_lds", 64'(slave_lds), 64'd0);
                chk("done_ack", 64'(master_ack), 64'(is_ack));
                chk("done_berr", 64'(master_berr), 64'(!is_ack));
                chk("done_read", 64'(master_read), 64'(m_read));
                chk("done_err_addr", 64'(err_addr), 64'(m_err));
            end
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            slave_ack = 4'($urandom); slave_read = {$urandom, $urandom};
            @(negedge clk);
            chk("hold_ack", 64'(master_ack), 64'(is_ack));
            chk("hold_berr", 64'(master_berr), 64'(!is_ack));
            chk("hold_read", 64'(master_read), 64'(m_read));
            chk("hold_uds", 64'(slave_uds), 64'd0);
        end

        @(posedge clk); #1;
        master_uds = 1'b0; master_lds = 1'b0; slave_ack = '0;
        @(negedge clk);
        chk("drop_ack", 64'(master_ack), 64'(is_ack));
        chk("drop_berr", 64'(master_berr), 64'(!is_ack));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_ack", 64'(master_ack), 64'd0);
        chk("rel_berr", 64'(master_berr), 64'd0);
        chk("rel_read", 64'(master_read), 64'(m_read));
        chk("rel_err_addr", 64'(err_addr), 64'(m_err));
    endtask

    // Master abandons a mapped transfer after k ACTIVE cycles (k <= TO-2).
    task automatic abort_xfer(input logic [31:0] a, input logic u, input logic l, input int k);
        int         sel;
        logic [3:0] eu, el, noise;
        sel = ref_decode(a);
        eu = '0; el = '0;
        if (sel >= 0) begin
            eu[sel] = u;
            el[sel] = l;
        end
        @(posedge clk); #1;
        master_addr = a; master_uds = u; master_lds = l;
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            noise = 4'($urandom);
            if (sel >= 0) noise[sel] = 1'b0;
            slave_ack = noise;
            @(negedge clk);
            chk("abort_act_uds", 64'(slave_uds), 64'(eu));
            chk("abort_act_lds", 64'(slave_lds), 64'(el));
        end
        @(posedge clk); #1;
        master_uds = 1'b0; master_lds = 1'b0; slave_ack = '0;
        for (int c = 0; c < TO + 2; c++) begin
            @(negedge clk);
            chk_quiet("abort");
            chk("abort_read", 64'(master_read), 64'(m_read));
            chk("abort_err_addr", 64'(err_addr), 64'(m_err));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  ul;
        reset = 1'b1;
        master_write = '0; master_addr = '0; master_uds = 1'b0; master_lds = 1'b0;
        slave_read = '0; slave_ack = '0;
        m_read = '0; m_err = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_read", 64'(master_read), 64'd0);
        chk("reset_err_addr", 64'(err_addr), 64'd0);
        reset = 1'b0;

        // RAM read, slave 0 acks in its third ACTIVE cycle.
        xfer(32'h00000400, 1'b1, 1'b1, 16'h0000, 3, 16'hBEEF, 1);
        // UART byte write on the lower lane.
        xfer(32'h00100004, 1'b0, 1'b1, 16'h0041, 2, 16'h1234, 0);
        // Unmapped address: immediate bus error.
        xfer(32'h00200000, 1'b1, 1'b1, 16'h5555, 1, 16'h0000, 2);
        // Slave 2 never answers: watchdog.
        xfer(32'h00100104, 1'b1, 1'b1, 16'hA5A5, 0, 16'h0000, 1);
        // Master aborts mid-transfer.
        abort_xfer(32'h00100020, 1'b1, 1'b0, 3);
        // Ack lands on the watchdog cycle (slave 3 via the wide window).
        xfer(32'h00100208, 1'b1, 1'b1, 16'h0F0F, TO, 16'hCAFE, 0);
        // Overlap: slave 1 wins over the wider slave 3 window.
        xfer(32'h001000F0, 1'b1, 0, 16'h0001, 1, 16'h7E57, 0);

        // Reset in the middle of a pending slave 1 transfer.
        @(posedge clk); #1;
        master_addr = 32'h00100010; master_uds = 1'b1; master_lds = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("prerst_uds", 64'(slave_uds), 64'b0010);
        end
        #2 reset = 1'b1;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_read", 64'(master_read), 64'd0);
        chk("async_rst_err_addr", 64'(err_addr), 64'd0);
        m_read = '0; m_err = '0;
        master_uds = 1'b0; master_lds = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        xfer(32'h00100010, 1'b1, 1'b1, 16'h3333, 2, 16'h4242, 0);

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       a = {12'h000, 20'($urandom)};
                1:       a = {24'h001000, 8'($urandom)};
                2:       a = {24'h001001, 8'($urandom)};
                3:       a = {12'h001, 20'($urandom)};
                default: a = $urandom;
            endcase
            ul = 2'($urandom_range(1, 3));
            xfer(a, ul[1], ul[0], 16'($urandom), int'($urandom_range(1, TO + 3)),
                 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
